// File: rtl/dehaze_frame_ctrl.sv
// dehaze_frame_ctrl: two-pass raster reader, pass 1 feeds the ALE, pass 2 the TE.
// Ports: clk/rst, start/hold, mem_*, ale_*, atm_light, te_*, busy/done/err/pass.
module dehaze_frame_ctrl #(
  parameter int WIDTH   = 512,
  parameter int HEIGHT  = 512,
  parameter int TIMEOUT = 65535,
  parameter int ADDR_W  = 18
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              hold,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd_en,
  input  logic [23:0]       mem_rdata,
  output logic [23:0]       ale_pixel,
  output logic              ale_valid,
  input  logic [23:0]       ale_result,
  input  logic              ale_result_valid,
  output logic [23:0]       atm_light,
  output logic [23:0]       te_pixel,
  output logic              te_valid,
  output logic              te_sof,
  output logic              te_eol,
  output logic              te_eof,
  input  logic              te_trans_valid,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [1:0]        pass
);

  localparam int N  = WIDTH * HEIGHT;
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int RW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam int NW = ADDR_W + 1;
  localparam int TW = $clog2(TIMEOUT + 1);

  localparam logic [ADDR_W-1:0] K_LAST = ADDR_W'(N - 1);
  localparam logic [NW-1:0]     N_CNT  = NW'(N);
  localparam logic [CW-1:0]     C_LAST = CW'(WIDTH - 1);
  localparam logic [RW-1:0]     R_LAST = RW'(HEIGHT - 1);
  localparam logic [TW-1:0]     T_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_P1_READ,
    S_P1_WAIT,
    S_P2_READ,
    S_P2_DRAIN,
    S_DONE
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] k_q, k_d;
  logic [CW-1:0]     col_q, col_d;
  logic [RW-1:0]     row_q, row_d;
  logic [NW-1:0]     cnt_q, cnt_d;
  logic [TW-1:0]     tmo_q, tmo_d;
  logic              err_q, err_d;
  logic [23:0]       atm_q, atm_d;

  // Read-issue stage: position flags travel with the read.
  logic s1_vld_q, s1_p2_q;
  logic s1_sof_q, s1_eol_q, s1_eof_q;

  logic [23:0] ale_pix_q, te_pix_q;
  logic        ale_vld_q, te_vld_q;
  logic        te_sof_q, te_eol_q, te_eof_q;

  logic rd_state, issue, last_rd;
  logic p2_state, cnt_inc;
  logic at_sof, at_eol, at_eof;

  assign rd_state = (state_q == S_P1_READ)
                 || (state_q == S_P2_READ);
  assign issue    = rd_state && !hold;
  assign last_rd  = (k_q == K_LAST);
  assign p2_state = (state_q == S_P2_READ)
                 || (state_q == S_P2_DRAIN);
  assign cnt_inc  = te_trans_valid && p2_state
                 && (cnt_q != N_CNT);

  assign at_sof = (row_q == '0) && (col_q == '0);
  assign at_eol = (col_q == C_LAST);
  assign at_eof = (row_q == R_LAST) && at_eol;

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    col_d   = col_q;
    row_d   = row_q;
    cnt_d   = cnt_q;
    tmo_d   = '0;
    err_d   = err_q;
    atm_d   = atm_q;

    if (cnt_inc) cnt_d = cnt_q + 1'b1;

    // The index parks on N-1 after the final read.
    if (issue && !last_rd) begin
      k_d = k_q + 1'b1;
      if (at_eol) begin
        col_d = '0;
        row_d = row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_P1_READ;
          k_d     = '0;
          col_d   = '0;
          row_d   = '0;
          cnt_d   = '0;
          err_d   = 1'b0;
        end
      end
      S_P1_READ: begin
        if (issue && last_rd) state_d = S_P1_WAIT;
      end
      S_P1_WAIT: begin
        tmo_d = tmo_q + 1'b1;
        if (ale_result_valid) begin
          atm_d   = ale_result;
          k_d     = '0;
          col_d   = '0;
          row_d   = '0;
          state_d = S_P2_READ;
        end else if (tmo_q == T_LAST) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end
      end
      S_P2_READ: begin
        if (issue && last_rd) state_d = S_P2_DRAIN;
      end
      S_P2_DRAIN: begin
        tmo_d = tmo_q + 1'b1;
        // Look at the next count so done follows the last sample directly.
        if (cnt_d == N_CNT) begin
          state_d = S_DONE;
        end else if (tmo_q == T_LAST) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      k_q     <= '0;
      col_q   <= '0;
      row_q   <= '0;
      cnt_q   <= '0;
      tmo_q   <= '0;
      err_q   <= 1'b0;
      atm_q   <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      col_q   <= col_d;
      row_q   <= row_d;
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
      err_q   <= err_d;
      atm_q   <= atm_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_vld_q  <= 1'b0;
      s1_p2_q   <= 1'b0;
      s1_sof_q  <= 1'b0;
      s1_eol_q  <= 1'b0;
      s1_eof_q  <= 1'b0;
      ale_pix_q <= '0;
      ale_vld_q <= 1'b0;
      te_pix_q  <= '0;
      te_vld_q  <= 1'b0;
      te_sof_q  <= 1'b0;
      te_eol_q  <= 1'b0;
      te_eof_q  <= 1'b0;
    end else begin
      s1_vld_q  <= issue;
      s1_p2_q   <= (state_q == S_P2_READ);
      s1_sof_q  <= at_sof;
      s1_eol_q  <= at_eol;
      s1_eof_q  <= at_eof;
      ale_vld_q <= s1_vld_q && !s1_p2_q;
      te_vld_q  <= s1_vld_q && s1_p2_q;
      te_sof_q  <= s1_vld_q && s1_p2_q && s1_sof_q;
      te_eol_q  <= s1_vld_q && s1_p2_q && s1_eol_q;
      te_eof_q  <= s1_vld_q && s1_p2_q && s1_eof_q;
      if (s1_vld_q && !s1_p2_q) ale_pix_q <= mem_rdata;
      if (s1_vld_q && s1_p2_q)  te_pix_q  <= mem_rdata;
    end
  end

  assign mem_addr  = k_q;
  assign mem_rd_en = issue;
  assign ale_pixel = ale_pix_q;
  assign ale_valid = ale_vld_q;
  assign atm_light = atm_q;
  assign te_pixel  = te_pix_q;
  assign te_valid  = te_vld_q;
  assign te_sof    = te_sof_q;
  assign te_eol    = te_eol_q;
  assign te_eof    = te_eof_q;
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);
  assign err       = err_q;
  assign pass      = (state_q == S_P1_READ
                   || state_q == S_P1_WAIT)  ? 2'd1 :
                     p2_state                 ? 2'd2 :
                                                2'd0;

endmodule

// File: tb/tb_dehaze_frame_ctrl.sv
// tb_dehaze_frame_ctrl: random frames vs a stream-level model of both passes.
// Covers hold, early ALE strobe, timeout, mid-frame reset, stray start/TE pulses.
module tb_dehaze_frame_ctrl;

  localparam int W      = 8;
  localparam int H      = 4;
  localparam int N      = W * H;
  localparam int TMO    = 20;
  localparam int AW     = 5;
  localparam int BUDGET = 600;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          hold = 1'b0;
  logic [AW-1:0] mem_addr;
  logic          mem_rd_en;
  logic [23:0]   mem_rdata = '0;
  logic [23:0]   ale_pixel;
  logic          ale_valid;
  logic [23:0]   ale_result = '0;
  logic          ale_result_valid = 1'b0;
  logic [23:0]   atm_light;
  logic [23:0]   te_pixel;
  logic          te_valid;
  logic          te_sof, te_eol, te_eof;
  logic          te_trans_valid = 1'b0;
  logic          busy, done, err;
  logic [1:0]    pass;

  logic [23:0] frame [0:N-1];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  dehaze_frame_ctrl #(
    .WIDTH  (W),
    .HEIGHT (H),
    .TIMEOUT(TMO),
    .ADDR_W (AW)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .start           (start),
    .hold            (hold),
    .mem_addr        (mem_addr),
    .mem_rd_en       (mem_rd_en),
    .mem_rdata       (mem_rdata),
    .ale_pixel       (ale_pixel),
    .ale_valid       (ale_valid),
    .ale_result      (ale_result),
    .ale_result_valid(ale_result_valid),
    .atm_light       (atm_light),
    .te_pixel        (te_pixel),
    .te_valid        (te_valid),
    .te_sof          (te_sof),
    .te_eol          (te_eol),
    .te_eof          (te_eof),
    .te_trans_valid  (te_trans_valid),
    .busy            (busy),
    .done            (done),
    .err             (err),
    .pass            (pass)
  );

  always @(posedge clk)
    if (mem_rd_en) mem_rdata <= frame[mem_addr];

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h",
               tag, got, exp);
    end
  endtask

  // hmode: 0 no hold, 1 every 3rd cycle, 2 random.
  // wh: TE samples withheld at frame end.
  // inj: stray TE pulses in IDLE and in pass 1.
  // rst_at: pass-2 address at which rst fires (-1 none).
  task automatic run_frame(input int hmode,
                           input int wh,
                           input logic [23:0] atm,
                           input bit early,
                           input bit dup,
                           input int inj,
                           input int rst_at);
    int c = 0;
    int ale_n = 0;
    int te_n = 0;
    int ale_due = -1;
    int last_rd = -1;
    int last_tr = -1;
    int done_c = -1;
    int dn = 0;
    int rs = 0;
    int rs_n = 0;
    int nb;
    bit both = 0;
    bit err_at = 0;
    bit early_done = 0;
    bit fin = 0;
    bit post = 0;
    bit stray = 0;
    logic [23:0] atm_at = '0;
    logic [26:0] texp;
    int due[$];
    int a1[$];
    int a2[$];
    logic [23:0] aq[$];
    logic [26:0] tq[$];

    for (int i = 0; i < N; i++) frame[i] = 24'($urandom);

    for (int i = 0; i < inj; i++) begin
      @(negedge clk);
      te_trans_valid = 1'b1;
    end
    @(negedge clk);
    te_trans_valid = 1'b0;
    start = 1'b1;

    while (!fin) begin
      @(negedge clk);
      c++;
      start = dup && (c == 5 || c == 50);
      case (hmode)
        1: hold = (c % 3 == 2);
        2: hold = ($urandom_range(0, 3) == 0);
        default: hold = 1'b0;
      endcase
      ale_result_valid = 1'b0;
      te_trans_valid   = 1'b0;
      #1;
      if (rs == 1) begin
        chk("rst_outputs_zero",
            |{mem_addr, mem_rd_en, ale_pixel, ale_valid,
              atm_light, te_pixel, te_valid, te_sof,
              te_eol, te_eof, busy, done, err, pass}, 0);
        rst = 1'b0;
        rs = 2;
      end else if (rs == 2) begin
        if (ale_valid || te_valid || busy || done || mem_rd_en)
          stray = 1'b1;
        rs_n++;
        if (rs_n == 20) fin = 1'b1;
      end else begin
        if (c == 1) begin
          chk("busy_after_start", busy, 1);
          chk("err_clear_on_start", err, 0);
        end
        if (post) begin
          chk("busy_fall", busy, 0);
          fin = 1'b1;
        end
        if (mem_rd_en) begin
          if (pass == 2'd1) a1.push_back(int'(mem_addr));
          else if (pass == 2'd2) begin
            a2.push_back(int'(mem_addr));
            last_rd = c;
          end else a1.push_back(-1);
          if (pass == 2'd2 && int'(mem_addr) == rst_at) begin
            rst = 1'b1;
            rs = 1;
          end
        end
        if (ale_valid && te_valid) both = 1'b1;
        if (ale_valid) begin
          aq.push_back(ale_pixel);
          ale_n++;
          if (ale_n == N) ale_due = c + 5;
        end
        if (te_valid) begin
          tq.push_back({te_sof, te_eol, te_eof, te_pixel});
          te_n++;
          if (te_n <= N - wh) due.push_back(c + 10);
        end
        if (done) begin
          dn++;
          done_c = c;
          err_at = err;
          atm_at = atm_light;
          post = 1'b1;
        end
        if (c == ale_due) begin
          ale_result_valid = 1'b1;
          ale_result = atm;
        end else if (early && !early_done && ale_n == 10) begin
          ale_result_valid = 1'b1;
          ale_result = ~atm;
          early_done = 1'b1;
        end
        if (due.size() > 0 && due[0] == c) begin
          void'(due.pop_front());
          te_trans_valid = 1'b1;
          last_tr = c;
        end
        if (c >= 3 && c < 3 + inj) te_trans_valid = 1'b1;
        if (c >= BUDGET) fin = 1'b1;
      end
    end

    hold = 1'b0;
    start = 1'b0;
    ale_result_valid = 1'b0;
    te_trans_valid = 1'b0;

    if (rs != 0) begin
      chk("rst_no_activity", stray, 0);
      return;
    end

    chk("done_once", dn, 1);
    chk("p1_addr_count", a1.size(), N);
    nb = 0;
    foreach (a1[i]) if (a1[i] != i) nb++;
    chk("p1_addr_order", nb, 0);
    chk("p2_addr_count", a2.size(), N);
    nb = 0;
    foreach (a2[i]) if (a2[i] != i) nb++;
    chk("p2_addr_order", nb, 0);
    chk("ale_count", aq.size(), N);
    nb = 0;
    foreach (aq[i]) if (aq[i] !== frame[i]) nb++;
    chk("ale_pixels", nb, 0);
    chk("te_count", tq.size(), N);
    nb = 0;
    foreach (tq[i]) begin
      texp = {i == 0, i % W == W - 1, i == N - 1, frame[i]};
      if (tq[i] !== texp) nb++;
    end
    chk("te_pixels_flags", nb, 0);
    chk("streams_exclusive", both, 0);
    chk("atm_light", atm_at, atm);
    chk("err_at_done", err_at, wh > 0);
    chk("err_in_idle", err, wh > 0);
    if (wh == 0) chk("done_latency", done_c - last_tr, 1);
    else chk("timeout_latency", done_c - last_rd, TMO + 1);
  endtask

  initial begin
    for (int i = 0; i < N; i++) frame[i] = '0;
    repeat (2) @(negedge clk);
    chk("reset_outputs_zero",
        |{mem_addr, mem_rd_en, ale_pixel, ale_valid,
          atm_light, te_pixel, te_valid, te_sof,
          te_eol, te_eof, busy, done, err, pass}, 0);
    rst = 1'b0;
    @(negedge clk);

    run_frame(0, 0, 24'hF0E0D0, 0, 0, 0, -1);
    run_frame(1, 0, 24'($urandom), 0, 0, 0, -1);
    run_frame(0, 0, 24'h112233, 1, 0, 0, -1);
    run_frame(0, 2, 24'($urandom), 0, 0, 0, -1);
    run_frame(2, 0, 24'($urandom), 0, 0, 0, -1);
    run_frame(2, 0, 24'($urandom), 0, 0, 0, 13);
    run_frame(0, 0, 24'($urandom), 0, 0, 0, -1);
    run_frame(0, 0, 24'($urandom), 0, 1, 3, -1);
    for (int r = 0; r < 3; r++)
      run_frame(2, 0, 24'($urandom), 0, 0, 0, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
